// File: rtl/timer_pkg.sv
// Shared types and frame constants for the timer scheduler.
package timer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        CHECK,
        WAIT,
        ACK,
        RECOVER
    } state_t;

    localparam logic [3:0] FRAME_HDR = 4'b1101;
    localparam int         FRAME_LEN = 9;
    localparam int         DELAY_W   = 4;

    // Bit idx (0 = first on the wire) of the trigger frame {header, spacer, code}.
    function automatic logic frame_bit(input logic [DELAY_W-1:0] code, input logic [3:0] idx);
        logic [FRAME_LEN-1:0] frame;
        frame = {FRAME_HDR, 1'b0, code} << idx;
        return frame[FRAME_LEN-1];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping around.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    int idx;

    // Scan requesters starting at the priority pointer; the first hit wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_valid && req[IW'(idx)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/timer_scheduler.sv
// Shares one serial-triggered delay timer among N requesters: arbitrates,
// sends the trigger frame, supervises start/done and reports per requester.
module timer_scheduler #(
    parameter int N        = 4,
    parameter int START_TO = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [4*N-1:0]       req_delay,
    output logic [N-1:0]         done_o,
    output logic [N-1:0]         err_o,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 tmr_data,
    output logic                 tmr_ack,
    input  logic                 tmr_counting,
    input  logic                 tmr_done
);

    import timer_pkg::*;

    localparam int IW = $clog2(N);
    localparam int TW = $clog2(START_TO) + 1;

    state_t               state_q, state_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]        to_cnt_q, to_cnt_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        gid_q, gid_d;
    logic [DELAY_W-1:0]   delay_q, delay_d;
    logic                 data_q, data_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic [N-1:0]         done_q, done_d;
    logic [N-1:0]         err_q, err_d;

    logic                 gnt_valid;
    logic [IW-1:0]        gnt_idx;
    logic [DELAY_W-1:0]   gnt_delay;

    rr_arbiter #(.N(N)) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Select the winning requester's delay nibble.
    always_comb begin
        gnt_delay = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == IW'(i)) begin
                gnt_delay = req_delay[i*DELAY_W +: DELAY_W];
            end
        end
    end

    // Next-state logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        to_cnt_d  = to_cnt_q;
        ptr_d     = ptr_q;
        gid_d     = gid_q;
        delay_d   = delay_q;
        data_d    = 1'b0;
        ack_d     = 1'b0;
        done_d    = '0;
        err_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d   = SEND;
                    gid_d     = gnt_idx;
                    delay_d   = gnt_delay;
                    ptr_d     = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
                    bit_cnt_d = '0;
                    data_d    = frame_bit(gnt_delay, 4'd0);
                end
            end
            SEND: begin
                if (bit_cnt_q == 4'(FRAME_LEN-1)) begin
                    state_d  = CHECK;
                    to_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    data_d    = frame_bit(delay_q, bit_cnt_d);
                end
            end
            CHECK: begin
                if (tmr_counting) begin
                    state_d = WAIT;
                end else if (to_cnt_q == TW'(START_TO-1)) begin
                    state_d = RECOVER;
                    err_d   = N'(1) << gid_q;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (tmr_done) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    done_d  = N'(1) << gid_q;
                end
            end
            ACK: begin
                state_d = RECOVER;
            end
            RECOVER: begin
                if (!tmr_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Control and output registers; reset abandons any service silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            ptr_q     <= '0;
            gid_q     <= '0;
            data_q    <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            to_cnt_q  <= to_cnt_d;
            ptr_q     <= ptr_d;
            gid_q     <= gid_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Delay code latched at grant; only meaningful while a service is active.
    always_ff @(posedge clk) begin
        delay_q <= delay_d;
    end

    assign done_o   = done_q;
    assign err_o    = err_q;
    assign busy     = busy_q;
    assign grant_id = gid_q;
    assign tmr_data = data_q;
    assign tmr_ack  = ack_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler with a behavioural frame-decoding timer model.
module tb_timer_scheduler;

    localparam int N        = 4;
    localparam int START_TO = 4;
    localparam int DW       = 4 * N;

    logic                 clk;
    logic                 reset;
    logic [N-1:0]         req;
    logic [DW-1:0]        req_delay;
    logic [N-1:0]         done_o;
    logic [N-1:0]         err_o;
    logic                 busy;
    logic [$clog2(N)-1:0] grant_id;
    logic                 tmr_data;
    logic                 tmr_ack;
    logic                 tmr_counting;
    logic                 tmr_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // timer model configuration and observations
    int         start_lat     = 2;    // cycles after last code bit until counting; <0 = never
    int         dur_base      = 10;   // counting length = dur_base + code
    int         trig_cnt      = 0;
    logic [3:0] last_code     = '0;
    int         done_rise_cyc = -1;
    int         tstate        = 0;

    int ref_ptr = 0;

    typedef struct {
        bit           ok;
        int           gid;
        logic [8:0]   frame;
        logic [N-1:0] done_acc;
        logic [N-1:0] err_acc;
        int           n_done;
        int           n_err;
        int           n_ack;
        int           c_first;
        int           c_done;
        int           c_err;
        int           c_ack;
        int           c_end;
    } svc_t;

    timer_scheduler #(.N(N), .START_TO(START_TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_delay    (req_delay),
        .done_o       (done_o),
        .err_o        (err_o),
        .busy         (busy),
        .grant_id     (grant_id),
        .tmr_data     (tmr_data),
        .tmr_ack      (tmr_ack),
        .tmr_counting (tmr_counting),
        .tmr_done     (tmr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural timer: detects header 1101, skips spacer, reads 4 code bits,
    // then counts and raises done until acknowledged. Runs on the falling edge.
    initial begin : timer_model
        logic [3:0] hist;
        logic [3:0] code;
        int bcnt;
        int wcnt;
        int dur;
        hist = '0; code = '0; bcnt = 0; wcnt = 0; dur = 0;
        tmr_counting = 1'b0;
        tmr_done     = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                tstate = 0; hist = '0;
                tmr_counting = 1'b0;
                tmr_done     = 1'b0;
            end else begin
                case (tstate)
                    0: begin
                        hist = {hist[2:0], tmr_data};
                        if (hist == 4'b1101) tstate = 1;
                    end
                    1: begin
                        tstate = 2; bcnt = 0; code = '0;
                    end
                    2: begin
                        code = {code[2:0], tmr_data};
                        bcnt++;
                        if (bcnt == 4) begin
                            trig_cnt++;
                            last_code = code;
                            hist = '0;
                            dur = dur_base + int'(code);
                            wcnt = 0;
                            tstate = (start_lat < 0) ? 0 : 3;
                        end
                    end
                    3: begin
                        wcnt++;
                        if (wcnt >= start_lat) begin
                            tmr_counting = 1'b1; wcnt = 0; tstate = 4;
                        end
                    end
                    4: begin
                        wcnt++;
                        if (wcnt >= dur) begin
                            tmr_counting = 1'b0; tmr_done = 1'b1;
                            done_rise_cyc = cyc; tstate = 5;
                        end
                    end
                    default: begin
                        if (tmr_ack) begin
                            tmr_done = 1'b0; tstate = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary, expected completion");
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (((r >> ((p + k) % N)) & N'(1)) != 0) return (p + k) % N;
        end
        return -1;
    endfunction

    // Observe one full service: waits for busy, records frame and pulses.
    task automatic serve_one(input bit keep, input int drop_at, output svc_t s);
        int i;
        s.ok = 0; s.gid = -1; s.frame = '0; s.done_acc = '0; s.err_acc = '0;
        s.n_done = 0; s.n_err = 0; s.n_ack = 0; s.c_first = -1;
        s.c_done = -1; s.c_err = -1; s.c_ack = -1; s.c_end = -1;
        i = 0;
        while (!busy && i < 50) begin tick(); i++; end
        if (!busy) return;
        s.gid = int'(grant_id);
        s.c_first = cyc;
        i = 0;
        while (busy && i < 400) begin
            if (i < 9) s.frame = {s.frame[7:0], tmr_data};
            if (i == drop_at) begin
                req = '0;
                req_delay = DW'($urandom);
            end
            if (done_o != '0) begin s.n_done++; s.done_acc |= done_o; s.c_done = cyc; end
            if (err_o != '0) begin s.n_err++; s.err_acc |= err_o; s.c_err = cyc; end
            if (tmr_ack) begin s.n_ack++; s.c_ack = cyc; end
            if (!keep) req = req & ~(done_o | err_o);
            tick();
            i++;
        end
        s.ok = !busy;
        s.c_end = cyc;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; req_delay = '0;
        repeat (3) tick();
        checks++;
        if ({done_o, err_o, busy, grant_id, tmr_data, tmr_ack} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {done_o, err_o, busy, grant_id, tmr_data, tmr_ack});
        end
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || tmr_data !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: busy=%b tmr_data=%b required 0/0", busy, tmr_data);
        end
        ref_ptr = 0;
    endtask

    task automatic test_single();
        svc_t s;
        int tc;
        start_lat = 2; dur_base = 40;
        req_delay = '0; req_delay[3:0] = 4'hA;
        tc = trig_cnt;
        req = N'(1);
        serve_one(0, -1, s);
        checks++;
        if (!s.ok || s.gid != 0) begin
            failures++;
            $display("FAIL single_grant: ok=%0d gid=%0d required ok=1 gid=0", s.ok, s.gid);
        end
        checks++;
        if (s.frame !== 9'b110101010) begin
            failures++;
            $display("FAIL single_frame: got %b required 110101010", s.frame);
        end
        checks++;
        if (s.n_done != 1 || s.done_acc !== N'(1)) begin
            failures++;
            $display("FAIL single_done: count=%0d mask=%b required 1/0001", s.n_done, s.done_acc);
        end
        checks++;
        if (s.n_ack != 1 || s.c_ack != done_rise_cyc + 1 || s.c_done != s.c_ack) begin
            failures++;
            $display("FAIL single_ack: acks=%0d ack_cyc=%0d done_cyc=%0d required 1 at %0d",
                     s.n_ack, s.c_ack, s.c_done, done_rise_cyc + 1);
        end
        checks++;
        if (s.n_err != 0 || trig_cnt - tc != 1 || last_code !== 4'hA) begin
            failures++;
            $display("FAIL single_timer: errs=%0d triggers=%0d code=%h required 0/1/a",
                     s.n_err, trig_cnt - tc, last_code);
        end
        ref_ptr = 1;
    endtask

    task automatic test_random();
        svc_t s;
        int exp;
        logic [3:0] expcode;
        for (int it = 0; it < 6; it++) begin
            start_lat = (it == 0) ? START_TO : int'($urandom_range(1, START_TO));
            dur_base  = int'($urandom_range(1, 20));
            req_delay = DW'($urandom);
            req       = N'($urandom_range(1, (1 << N) - 1));
            for (int k = 0; k < N && req != '0; k++) begin
                exp = rr_pick(req, ref_ptr);
                expcode = 4'(req_delay >> (4 * exp));
                serve_one(0, -1, s);
                checks++;
                if (!s.ok || s.gid != exp) begin
                    failures++;
                    $display("FAIL rand_grant: it=%0d ok=%0d gid=%0d required %0d", it, s.ok, s.gid, exp);
                end
                checks++;
                if (s.frame !== {4'b1101, 1'b0, expcode}) begin
                    failures++;
                    $display("FAIL rand_frame: it=%0d got %b required %b", it, s.frame,
                             {4'b1101, 1'b0, expcode});
                end
                checks++;
                if (s.n_done != 1 || s.n_err != 0 || s.done_acc !== (N'(1) << exp)) begin
                    failures++;
                    $display("FAIL rand_done: it=%0d dones=%0d errs=%0d mask=%b required one pulse on %0d",
                             it, s.n_done, s.n_err, s.done_acc, exp);
                end
                ref_ptr = (exp + 1) % N;
            end
            checks++;
            if (req != '0) begin
                failures++;
                $display("FAIL rand_all_served: it=%0d left=%b required 0", it, req);
            end
        end
    endtask

    task automatic test_round_robin();
        svc_t s;
        int exp;
        reset = 1'b1; tick(); reset = 1'b0; tick();
        ref_ptr = 0;
        start_lat = 1; dur_base = 3;
        req_delay = DW'($urandom);
        req = '1;
        for (int i = 0; i < 5; i++) begin
            exp = rr_pick(req, ref_ptr);
            serve_one(1, -1, s);
            checks++;
            if (s.gid != exp || s.n_done != 1 || s.done_acc !== (N'(1) << exp)) begin
                failures++;
                $display("FAIL rr_order: svc=%0d gid=%0d dones=%0d mask=%b required gid %0d one pulse",
                         i, s.gid, s.n_done, s.done_acc, exp);
            end
            ref_ptr = (exp + 1) % N;
        end
        req = '0;
        tick();
    endtask

    task automatic test_timeout();
        svc_t s;
        int idx;
        start_lat = -1;
        idx = int'($urandom_range(0, N - 1));
        req_delay = DW'($urandom);
        req = N'(1) << idx;
        serve_one(0, -1, s);
        checks++;
        if (!s.ok || s.n_err != 1 || s.err_acc !== (N'(1) << idx)) begin
            failures++;
            $display("FAIL timeout_err: ok=%0d errs=%0d mask=%b required one pulse on %0d",
                     s.ok, s.n_err, s.err_acc, idx);
        end
        checks++;
        if (s.c_err != s.c_first + 9 + START_TO) begin
            failures++;
            $display("FAIL timeout_time: err at +%0d required +%0d", s.c_err - s.c_first, 9 + START_TO);
        end
        checks++;
        if (s.n_ack != 0 || s.n_done != 0) begin
            failures++;
            $display("FAIL timeout_noack: acks=%0d dones=%0d required 0/0", s.n_ack, s.n_done);
        end
        ref_ptr = (idx + 1) % N;
        start_lat = 2;
    endtask

    task automatic test_delay_change();
        svc_t s;
        start_lat = 2; dur_base = 5;
        req_delay = DW'($urandom);
        req_delay[11:8] = 4'h5;
        req = N'(4);
        serve_one(0, 3, s);
        checks++;
        if (s.gid != 2 || s.frame !== 9'b110100101) begin
            failures++;
            $display("FAIL change_frame: gid=%0d frame=%b required 2/110100101", s.gid, s.frame);
        end
        checks++;
        if (s.n_done != 1 || s.done_acc !== N'(4)) begin
            failures++;
            $display("FAIL change_done: dones=%0d mask=%b required 1/0100", s.n_done, s.done_acc);
        end
        ref_ptr = 3;
    endtask

    task automatic test_reset_mid_wait();
        svc_t s;
        int i;
        start_lat = 2; dur_base = 100;
        req_delay[11:8] = 4'h3;
        req = N'(4);
        i = 0;
        while (!busy && i < 50) begin tick(); i++; end
        repeat (15) tick();
        checks++;
        if (busy !== 1'b1 || tmr_ack !== 1'b0 || done_o !== '0) begin
            failures++;
            $display("FAIL rmw_in_wait: busy=%b ack=%b done=%b required 1/0/0", busy, tmr_ack, done_o);
        end
        reset = 1'b1; req = '0;
        tick();
        reset = 1'b0;
        checks++;
        if ({done_o, err_o, busy, grant_id, tmr_data, tmr_ack} !== '0) begin
            failures++;
            $display("FAIL rmw_outputs: got %b required all zero",
                     {done_o, err_o, busy, grant_id, tmr_data, tmr_ack});
        end
        ref_ptr = 0;
        start_lat = 1; dur_base = 2;
        req = N'(10);
        serve_one(0, -1, s);
        checks++;
        if (s.gid != 1 || s.done_acc !== N'(2)) begin
            failures++;
            $display("FAIL rmw_first_grant: gid=%0d mask=%b required 1/0010", s.gid, s.done_acc);
        end
        serve_one(0, -1, s);
        checks++;
        if (s.gid != 3 || s.done_acc !== N'(8)) begin
            failures++;
            $display("FAIL rmw_second_grant: gid=%0d mask=%b required 3/1000", s.gid, s.done_acc);
        end
        ref_ptr = 0;
    endtask

    task automatic test_integration();
        svc_t s;
        int tc;
        start_lat = 1; dur_base = 1;
        req_delay = '0;
        tc = trig_cnt;
        req = N'(8);
        serve_one(0, -1, s);
        checks++;
        if (!s.ok || s.n_done != 1 || s.done_acc !== N'(8) || last_code !== 4'h0) begin
            failures++;
            $display("FAIL integ_done: ok=%0d dones=%0d mask=%b code=%h required 1/1/1000/0",
                     s.ok, s.n_done, s.done_acc, last_code);
        end
        checks++;
        if (s.c_end - s.c_first != 13) begin
            failures++;
            $display("FAIL integ_length: busy cycles=%0d required 13", s.c_end - s.c_first);
        end
        repeat (10) tick();
        checks++;
        if (trig_cnt - tc != 1 || tstate != 0 || tmr_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL integ_idle: triggers=%0d timer_state=%0d done=%b busy=%b required 1/0/0/0",
                     trig_cnt - tc, tstate, tmr_done, busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        req_delay = '0;
        test_reset();
        test_single();
        test_random();
        test_round_robin();
        test_timeout();
        test_delay_change();
        test_reset_mid_wait();
        test_integration();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

- Shares one serial-triggered delay timer between `N` requesters.
- Arbitrates round-robin among pending requests and serialises the winner's 4-bit delay code into the timer's trigger frame.
- Verifies that the timer starts, waits for its `done`, acknowledges it, and returns a per-requester completion or error pulse.
- Sits between client logic and the timer instance; it is the only driver of the timer's `data` and `ack` inputs.

## Interface
Parameters:
- `N`, default 4: number of requesters, range 2..8.
- `START_TO`, default 4: cycles after the last frame bit within which `tmr_counting` must rise.

Ports:
- `clk`, in, 1: clock; all logic rising-edge.
- `reset`, in, 1: synchronous, active-high; shared with the timer.
- `req`, in, N: level request per requester; held until that requester's `done_o` or `err_o` pulse.
- `req_delay`, in, 4N: delay code; requester i uses bits [4i+3:4i].
- `done_o`, out, N: one-cycle completion pulse to the served requester.
- `err_o`, out, N: one-cycle pulse when the timer failed to start.
- `busy`, out, 1: high in every state except IDLE.
- `grant_id`, out, $clog2(N): index of the requester being served; valid while `busy`.
- `tmr_data`, out, 1: serial trigger line to the timer.
- `tmr_ack`, out, 1: acknowledge to the timer.
- `tmr_counting`, in, 1: timer is counting.
- `tmr_done`, in, 1: timer expired.

## Operation
- **Reset values:**
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer is 0, meaning requester 0 has highest priority.
  - Reset mid-operation abandons service with no pulses.
- **IDLE:**
  - `tmr_data`=0.
  - If any `req` bit is set, the arbiter picks the first set bit at or after the pointer, wrapping around.
  - Latch `grant_id` and that requester's `req_delay` nibble, then go to SEND.
  - The pointer becomes grant+1 mod N.
- **SEND:**
  - Drives the 9-bit frame 1,1,0,1,0,d3,d2,d1,d0, one bit per cycle, MSB first, from the latched code.
  - The fifth bit is a fixed 0 spacer: the timer consumes the cycle after header detection before sampling delay bits.
  - After bit 9, go to CHECK.
- **CHECK:**
  - `tmr_data`=0.
  - If `tmr_counting` is seen within `START_TO` cycles, go to WAIT.
  - Otherwise pulse `err_o[grant_id]` and go to RECOVER.
- **WAIT:**
  - Hold until `tmr_done`=1, with no timeout.
  - Then go to ACK.
- **ACK:**
  - One cycle with `tmr_ack`=1 and `done_o[grant_id]`=1.
  - Go to RECOVER.
- **RECOVER:**
  - `tmr_data`=0 and `tmr_ack`=0.
  - Stay at least 1 cycle and until `tmr_done`=0, then go to IDLE.
- **Request handling:**
  - The delay code is sampled only at grant; later changes are ignored.
  - A `req` bit dropped during service is ignored; service completes and the pulse still fires.
- **Simultaneous events:**
  - Requests arriving while `busy` wait; none are lost, because `req` is level.
  - `tmr_done` already high on entry to WAIT is accepted in that cycle.

## Timing
- `req` rises in cycle t with the controller IDLE:
  - SEND starts at t+1; `tmr_data` carries frame bit 1 in t+1 and bit 9 in t+9.
  - CHECK starts at t+10.
- `tmr_done` is sampled high in cycle u during WAIT: ACK occurs at u+1.
- Minimum IDLE-to-IDLE service is 13 cycles plus the timer duration.
- The earliest next grant is the cycle after return to IDLE.
- All outputs are registered; no combinational path from `tmr_*` inputs to outputs.

## Structure
- Shared package `timer_pkg`:
  - State enum (IDLE, SEND, CHECK, WAIT, ACK, RECOVER).
  - `FRAME_HDR`=4'b1101, `FRAME_LEN`=9, `DELAY_W`=4.
- Sub-module `rr_arbiter` (N): inputs `req` and `ptr`; outputs `gnt_valid` and `gnt_idx`. Purely combinational.
- The top holds the FSM, frame bit counter (4 bits), start-timeout counter, latched delay and pointer.

## Test plan
- **Single request:** `req`=0001, delay 4'hA, stub timer raises `tmr_counting` 2 cycles after the frame and `tmr_done` 50 cycles later.
  - `tmr_data` = 1,1,0,1,0,1,0,1,0 in cycles 1..9.
  - One `tmr_ack` pulse and `done_o`=0001 exactly 1 cycle after `tmr_done`.
- **Round-robin:** `req`=1111 held continuously.
  - Grants occur in order 0,1,2,3,0.
  - Each requester receives exactly one `done_o` per service.
- **Start timeout:** stub never asserts `tmr_counting`.
  - `err_o[grant_id]` pulses `START_TO` cycles after CHECK entry.
  - No `tmr_ack`; back to IDLE.
- **Delay change and request drop:** change `req_delay` and drop `req` during SEND.
  - The frame still carries the grant-time code.
  - `done_o` still pulses.
- **Reset mid-WAIT:** assert `reset` for 1 cycle.
  - All outputs are 0 the next cycle.
  - The pointer returns to 0, and a subsequent `req`=1010 grants requester 1 first.
- **Integration:** drive the real timer instance with delay 0.
  - `done_o` fires; the timer returns to its idle state, and no false trigger occurs during RECOVER.
